// File: rtl/spu_inst_fetch.sv
// Instruction fetch unit for the dual-issue SPU: prefetches 64-bit pairs into a show-ahead buffer.
// Optional macro SPU_FETCH_PERF_CNT_EN adds saturating stall/redirect performance counters.
module spu_inst_fetch #(
    parameter int          ADDR_W   = 15,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [63:0]       imem_rdata,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    output logic              inst_valid,
    output logic [31:0]       first_inst,
    output logic [31:0]       second_inst,
    output logic              first_valid,
    output logic [31:0]       pc_output
`ifdef SPU_FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_redirect_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        REDIRECT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              req_int;

    logic [ADDR_W-1:0] fetch_pc;
    logic              odd_pending;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight_odd;

    logic [63:0]       data_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DEPTH-1:0]  odd_mem;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic              buf_valid;
    logic              push;
    logic              pop;
    logic              write_en;
    logic [CNT_W-1:0]  credit;
    logic              unused_target_bits;

    assign unused_target_bits = ^{branch_target[31:ADDR_W], branch_target[1:0]};

    assign buf_valid = (count != '0);
    assign push      = inflight;
    assign pop       = buf_valid && !stall;
    assign write_en  = reset && !branch_taken && push;
    assign credit    = count + CNT_W'(inflight);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A redirect pulse in any state restarts the one-cycle REDIRECT bubble.
    always_comb begin
        state_next = state;
        req_int    = 1'b0;
        case (state)
            IDLE:     state_next = FETCH;
            FETCH:    req_int    = (credit < CNT_W'(DEPTH));
            REDIRECT: state_next = FETCH;
            default:  state_next = IDLE;
        endcase
        if (branch_taken) begin
            state_next = REDIRECT;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            fetch_pc     <= {RESET_PC[ADDR_W-1:3], 3'b000};
            odd_pending  <= 1'b0;
            inflight     <= 1'b0;
            inflight_pc  <= '0;
            inflight_odd <= 1'b0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
        end else if (branch_taken) begin
            // Clearing inflight drops the response of any request made this cycle or last.
            fetch_pc     <= {branch_target[ADDR_W-1:3], 3'b000};
            odd_pending  <= branch_target[2];
            inflight     <= 1'b0;
            inflight_odd <= 1'b0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            count    <= count + CNT_W'(push) - CNT_W'(pop);
            inflight <= req_int;
            if (req_int) begin
                inflight_pc  <= fetch_pc;
                inflight_odd <= odd_pending;
                odd_pending  <= 1'b0;
                fetch_pc     <= fetch_pc + ADDR_W'(8);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (write_en) begin
            data_mem[tail] <= imem_rdata;
            pc_mem[tail]   <= inflight_pc;
            odd_mem[tail]  <= inflight_odd;
        end
    end

    assign imem_req    = reset && req_int;
    assign imem_addr   = imem_req ? fetch_pc : '0;
    assign inst_valid  = reset && buf_valid;
    assign first_valid = inst_valid && !odd_mem[head];
    assign first_inst  = first_valid ? data_mem[head][63:32] : 32'h0;
    assign second_inst = inst_valid ? data_mem[head][31:0] : 32'h0;
    assign pc_output   = inst_valid ? {{(32-ADDR_W){1'b0}}, pc_mem[head]} : 32'h0;

`ifdef SPU_FETCH_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            perf_stall_cnt    <= '0;
            perf_redirect_cnt <= '0;
        end else begin
            if (buf_valid && stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (branch_taken && (perf_redirect_cnt != 32'hFFFF_FFFF)) begin
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spu_inst_fetch.sv
// Self-checking bench for spu_inst_fetch: scoreboard of expected pairs plus directed timing checks.
// Perf counter checks are compiled in only when SPU_FETCH_PERF_CNT_EN is defined.
module tb_spu_inst_fetch;

    localparam int ADDR_W = 15;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic        fv;
        logic [31:0] first;
        logic [31:0] second;
    } exp_t;

    logic              clock;
    logic              reset;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [63:0]       imem_rdata;
    logic              stall;
    logic              branch_taken;
    logic [31:0]       branch_target;
    logic              inst_valid;
    logic [31:0]       first_inst;
    logic [31:0]       second_inst;
    logic              first_valid;
    logic [31:0]       pc_output;
`ifdef SPU_FETCH_PERF_CNT_EN
    logic [31:0]       perf_stall_cnt;
    logic [31:0]       perf_redirect_cnt;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t mon_exp;
    logic [31:0] head_pc_at_stall;

    spu_inst_fetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clock        (clock),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .inst_valid   (inst_valid),
        .first_inst   (first_inst),
        .second_inst  (second_inst),
        .first_valid  (first_valid),
        .pc_output    (pc_output)
`ifdef SPU_FETCH_PERF_CNT_EN
        ,
        .perf_stall_cnt   (perf_stall_cnt),
        .perf_redirect_cnt(perf_redirect_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Local store model: word at byte address A holds A; data returns one cycle after a request.
    always @(posedge clock) begin
        if (imem_req) begin
            imem_rdata <= {32'(imem_addr), 32'(imem_addr) + 32'd4};
        end else begin
            imem_rdata <= 64'hDEAD_BEEF_BAD0_BAD0;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic b, input logic [31:0] t);
        stall         = s;
        branch_taken  = b;
        branch_target = t;
    endtask

    task automatic nextCycle;
        @(posedge clock);
        #1;
    endtask

    task automatic atSample;
        @(negedge clock);
    endtask

    task automatic pushSeq(input logic [31:0] start, input int n, input logic odd);
        exp_t        e;
        logic [31:0] base;
        base = start & 32'h0000_7FF8;
        for (int i = 0; i < n; i++) begin
            e.pc     = (base + 32'(8 * i)) & 32'h0000_7FFF;
            e.fv     = !(odd && (i == 0));
            e.first  = e.fv ? e.pc : 32'h0;
            e.second = e.pc + 32'd4;
            exp_q.push_back(e);
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            nextCycle();
            applyStimulus(1'b0, 1'b0, 32'h0);
            atSample();
        end
    endtask

    // Branch pulse for one cycle, then re-seed the scoreboard with the target sequence.
    task automatic doBranch(input logic s, input logic [31:0] target);
        nextCycle();
        applyStimulus(s, 1'b1, target);
        atSample();
        nextCycle();
        applyStimulus(s, 1'b0, 32'h0);
        exp_q.delete();
        pushSeq(target, 40, target[2]);
        atSample();
        checkOutput("redirect_inst_valid", 64'(inst_valid), 64'(0));
        checkOutput("redirect_imem_req", 64'(imem_req), 64'(0));
    endtask

    // Monitor: compares the presented pair with the scoreboard head; pops on a transfer.
    always @(negedge clock) begin
        if (reset && !branch_taken && inst_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_pair actual_pc=0x%0h required=none", pc_output);
            end else begin
                mon_exp = exp_q[0];
                checkOutput("pair_pc", 64'(pc_output), 64'(mon_exp.pc));
                checkOutput("pair_first_valid", 64'(first_valid), 64'(mon_exp.fv));
                checkOutput("pair_first_inst", 64'(first_inst), 64'(mon_exp.first));
                checkOutput("pair_second_inst", 64'(second_inst), 64'(mon_exp.second));
                if (!stall) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before end of test");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);

        // Reset held low for three edges: every output must read 0.
        repeat (3) nextCycle();
        atSample();
        checkOutput("reset_imem_req", 64'(imem_req), 64'(0));
        checkOutput("reset_imem_addr", 64'(imem_addr), 64'(0));
        checkOutput("reset_inst_valid", 64'(inst_valid), 64'(0));
        checkOutput("reset_first_valid", 64'(first_valid), 64'(0));
        checkOutput("reset_pc_output", 64'(pc_output), 64'(0));
        checkOutput("reset_insts", {first_inst, second_inst}, 64'(0));
        pushSeq(32'h0, 64, 1'b0);
        nextCycle();
        reset = 1'b1;

        // Start-up latency: request in cycle 1, data back in cycle 2, presented in cycle 3.
        nextCycle();
        atSample();
        checkOutput("start_c1_req", 64'(imem_req), 64'(1));
        checkOutput("start_c1_addr", 64'(imem_addr), 64'(0));
        checkOutput("start_c1_valid", 64'(inst_valid), 64'(0));
        nextCycle();
        atSample();
        checkOutput("start_c2_req", 64'(imem_req), 64'(1));
        checkOutput("start_c2_addr", 64'(imem_addr), 64'h8);
        checkOutput("start_c2_valid", 64'(inst_valid), 64'(0));
        for (int i = 0; i < 6; i++) begin
            nextCycle();
            atSample();
            checkOutput("stream_no_gap", 64'(inst_valid), 64'(1));
        end

        // Back-pressure: ten stalled cycles fill the buffer and stop requests.
        nextCycle();
        head_pc_at_stall = exp_q[0].pc;
        applyStimulus(1'b1, 1'b0, 32'h0);
        atSample();
        for (int i = 0; i < 9; i++) begin
            nextCycle();
            atSample();
        end
        checkOutput("full_imem_req", 64'(imem_req), 64'(0));
        checkOutput("full_inst_valid", 64'(inst_valid), 64'(1));
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        atSample();
        checkOutput("release_full_req", 64'(imem_req), 64'(0));
        nextCycle();
        atSample();
        checkOutput("release_refill_req", 64'(imem_req), 64'(1));
        checkOutput("release_refill_addr", 64'(imem_addr),
                    64'((head_pc_at_stall + 32'(8 * DEPTH)) & 32'h7FFF));
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            atSample();
            checkOutput("release_no_gap", 64'(inst_valid), 64'(1));
        end
        checkOutput("pre_branch_inflight", 64'(imem_req), 64'(1));

        // Aligned redirect while a response is in flight.
        doBranch(1'b0, 32'h0000_0100);
        nextCycle();
        atSample();
        checkOutput("aligned_req", 64'(imem_req), 64'(1));
        checkOutput("aligned_addr", 64'(imem_addr), 64'h100);
        idleCycles(6);

        // Odd-word redirect: first slot suppressed.
        doBranch(1'b0, 32'h0000_0204);
        nextCycle();
        atSample();
        checkOutput("odd_addr", 64'(imem_addr), 64'h200);
        idleCycles(6);

        // Address wrap at the top of the local store.
        doBranch(1'b0, 32'h0000_7FE0);
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            atSample();
        end
        checkOutput("wrap_addr_top", 64'(imem_addr), 64'h7FF8);
        nextCycle();
        atSample();
        checkOutput("wrap_req", 64'(imem_req), 64'(1));
        checkOutput("wrap_addr_zero", 64'(imem_addr), 64'h0);
        idleCycles(6);

        // Redirect while stalled and full: branch wins over stall.
        for (int i = 0; i < 8; i++) begin
            nextCycle();
            applyStimulus(1'b1, 1'b0, 32'h0);
            atSample();
        end
        checkOutput("stall_full_req", 64'(imem_req), 64'(0));
        doBranch(1'b1, 32'h0000_0400);
        idleCycles(8);

        // Back-to-back redirects: the later target wins.
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'h0000_0300);
        atSample();
        doBranch(1'b0, 32'h0000_0504);
        nextCycle();
        atSample();
        checkOutput("b2b_addr", 64'(imem_addr), 64'h500);
        idleCycles(6);

        // Reset mid-operation, then perf counter scenario.
        nextCycle();
        reset = 1'b0;
        atSample();
        checkOutput("midreset_inst_valid", 64'(inst_valid), 64'(0));
        checkOutput("midreset_imem_req", 64'(imem_req), 64'(0));
        nextCycle();
        exp_q.delete();
        atSample();
        checkOutput("midreset_pc_output", 64'(pc_output), 64'(0));
`ifdef SPU_FETCH_PERF_CNT_EN
        checkOutput("perf_stall_reset", 64'(perf_stall_cnt), 64'(0));
        checkOutput("perf_redirect_reset", 64'(perf_redirect_cnt), 64'(0));
`endif
        pushSeq(32'h0, 40, 1'b0);
        nextCycle();
        reset = 1'b1;
        idleCycles(4);
        checkOutput("restart_valid", 64'(inst_valid), 64'(1));
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            applyStimulus(1'b1, 1'b0, 32'h0);
            atSample();
        end
        idleCycles(3);
        doBranch(1'b0, 32'h0000_0100);
        idleCycles(6);
        doBranch(1'b0, 32'h0000_0108);
        idleCycles(6);
`ifdef SPU_FETCH_PERF_CNT_EN
        checkOutput("perf_stall_cnt", 64'(perf_stall_cnt), 64'(5));
        checkOutput("perf_redirect_cnt", 64'(perf_redirect_cnt), 64'(2));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
